ibex_cheri_wb_stage: RTL and testbench

Single-entry writeback stage directly downstream of the execute block. It captures the retiring instruction's integer or capability result, or its destination for a pending load. It waits for the LSU response where needed, then drives one write to the merged integer/capability register file. It also provides the writeback-done signal the ID stage uses for stall and retire decisions.

---
 rtl/ibex_pkg.sv | 25 ++
 rtl/ibex_cheri_wb_mux.sv | 37 +++
 rtl/ibex_cheri_wb_stage.sv | 180 ++++++++++++++++++
 tb/tb_ibex_cheri_wb_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared types and helpers for the CHERI writeback stage.
//   wb_instr_type_e : class of instruction held in writeback
//   CheriCapWidth   : default capability width including tag
//   CheriTagBit     : bit position of the capability tag
//   int_to_cap()    : zero-extends a 32-bit integer into an untagged capability
package ibex_pkg;

  localparam int CheriCapWidth = 91;
  localparam int CheriTagBit   = CheriCapWidth - 1;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'b00,
    WB_INSTR_STORE = 2'b01,
    WB_INSTR_OTHER = 2'b10
  } wb_instr_type_e;

  function automatic logic [CheriCapWidth-1:0] int_to_cap(logic [31:0] data);
    logic [CheriCapWidth-1:0] cap;
    cap              = '0;
    cap[31:0]        = data;
    cap[CheriTagBit] = 1'b0;
    return cap;
  endfunction

endpackage

// File: rtl/ibex_cheri_wb_mux.sv
// Selects the final register-file write data for the writeback stage.
// Ports:
//   instr_type_i    : wb_instr_type_e of the instruction
//   cap_flag_i      : EX produced a capability result
//   lsu_cap_i       : LSU response is a capability load
//   rf_wdata_ex_i   : integer result from EX
//   cap_wdata_ex_i  : capability result from EX
//   rf_wdata_lsu_i  : integer load data
//   cap_wdata_lsu_i : capability load data
//   wdata_o         : full-width write data (integers are untagged, zero-extended)
module ibex_cheri_wb_mux #(
  parameter int CheriCapWidth = 91
) (
  input  logic [1:0]               instr_type_i,
  input  logic                     cap_flag_i,
  input  logic                     lsu_cap_i,
  input  logic [31:0]              rf_wdata_ex_i,
  input  logic [CheriCapWidth-1:0] cap_wdata_ex_i,
  input  logic [31:0]              rf_wdata_lsu_i,
  input  logic [CheriCapWidth-1:0] cap_wdata_lsu_i,
  output logic [CheriCapWidth-1:0] wdata_o
);
  import ibex_pkg::*;

  always_comb begin
    wdata_o = '0;
    case (instr_type_i)
      WB_INSTR_OTHER:
        wdata_o = cap_flag_i ? cap_wdata_ex_i : CheriCapWidth'(int_to_cap(rf_wdata_ex_i));
      WB_INSTR_LOAD:
        wdata_o = lsu_cap_i ? cap_wdata_lsu_i : CheriCapWidth'(int_to_cap(rf_wdata_lsu_i));
      default:
        wdata_o = '0;
    endcase
  end

endmodule

// File: rtl/ibex_cheri_wb_stage.sv
// Single-entry writeback stage. Holds one retiring instruction (integer or
// capability result, or the destination of a pending load/store), waits for
// the LSU response where needed and drives one write into the merged
// integer/capability register file.
//
// Optional feature: define IBEX_CHERI_WB_FWD_EN to expose the held OTHER
// result before retirement on rf_wdata_fwd_wb_o / rf_waddr_fwd_wb_o /
// rf_fwd_valid_o.
//
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   en_wb_i ... cap_wdata_id_i : instruction handed over from ID/EX
//   lsu_*                  : LSU response for the held load/store
//   ready_wb_o             : stage can accept this cycle
//   rf_waddr_wb_o, rf_we_wb_o, cap_wdata_wb_o : register file write port
//   instr_done_wb_o        : retire pulse
//   outstanding_load_wb_o  : held memory op awaiting response
//   lsu_err_wb_o           : retiring memory op had an error
//   pc_wb_o                : PC of the held instruction
//
// state | meaning
// ------+-------------------------------------------------
// EMPTY | wb_valid_q=0, nothing held, ready to accept
// HELD  | wb_valid_q=1, one instruction waiting to retire
module ibex_cheri_wb_stage #(
  parameter int CheriCapWidth = 91,
  parameter bit ResetAll      = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_wb_i,
  input  logic [1:0]               instr_type_wb_i,
  input  logic [31:0]              pc_id_i,
  input  logic [4:0]               rf_waddr_id_i,
  input  logic                     rf_we_id_i,
  input  logic [31:0]              rf_wdata_id_i,
  input  logic                     cap_we_id_i,
  input  logic [CheriCapWidth-1:0] cap_wdata_id_i,
  input  logic                     lsu_resp_valid_i,
  input  logic                     lsu_resp_err_i,
  input  logic                     lsu_cap_i,
  input  logic [31:0]              rf_wdata_lsu_i,
  input  logic [CheriCapWidth-1:0] cap_wdata_lsu_i,
  output logic                     ready_wb_o,
  output logic [4:0]               rf_waddr_wb_o,
  output logic                     rf_we_wb_o,
  output logic [CheriCapWidth-1:0] cap_wdata_wb_o,
  output logic                     instr_done_wb_o,
  output logic                     outstanding_load_wb_o,
  output logic                     lsu_err_wb_o,
  output logic [31:0]              pc_wb_o
`ifdef IBEX_CHERI_WB_FWD_EN
  ,
  output logic [CheriCapWidth-1:0] rf_wdata_fwd_wb_o,
  output logic [4:0]               rf_waddr_fwd_wb_o,
  output logic                     rf_fwd_valid_o
`endif
);
  import ibex_pkg::*;

  logic                     wb_valid_q;
  wb_instr_type_e           type_q;
  logic                     we_q;
  logic                     cap_q;
  logic [4:0]               waddr_q;
  logic [31:0]              rf_wdata_q;
  logic [CheriCapWidth-1:0] cap_wdata_q;
  logic [31:0]              pc_q;

  logic                     wb_done;
  logic                     accept;
  logic                     is_other;
  logic                     waddr_nz;
  logic [CheriCapWidth-1:0] wb_wdata;

  assign is_other   = (type_q == WB_INSTR_OTHER);
  assign waddr_nz   = (waddr_q != 5'd0);
  assign wb_done    = wb_valid_q & (is_other | lsu_resp_valid_i);
  // Retiring and accepting in the same cycle keeps back-to-back throughput.
  assign ready_wb_o = ~wb_valid_q | wb_done;
  assign accept     = en_wb_i & ready_wb_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_q <= 1'b0;
      type_q     <= WB_INSTR_LOAD;
      we_q       <= 1'b0;
      cap_q      <= 1'b0;
    end else if (accept) begin
      wb_valid_q <= 1'b1;
      type_q     <= wb_instr_type_e'(instr_type_wb_i);
      we_q       <= rf_we_id_i;
      cap_q      <= cap_we_id_i;
    end else if (wb_done) begin
      wb_valid_q <= 1'b0;
    end
  end

  // Data flops are only meaningful while wb_valid_q is set, so their reset is optional.
  if (ResetAll) begin : g_data_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        waddr_q     <= '0;
        rf_wdata_q  <= '0;
        cap_wdata_q <= '0;
        pc_q        <= '0;
      end else if (accept) begin
        waddr_q     <= rf_waddr_id_i;
        rf_wdata_q  <= rf_wdata_id_i;
        cap_wdata_q <= cap_wdata_id_i;
        pc_q        <= pc_id_i;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk_i) begin
      if (accept) begin
        waddr_q     <= rf_waddr_id_i;
        rf_wdata_q  <= rf_wdata_id_i;
        cap_wdata_q <= cap_wdata_id_i;
        pc_q        <= pc_id_i;
      end
    end
  end

  ibex_cheri_wb_mux #(
    .CheriCapWidth(CheriCapWidth)
  ) u_wb_mux (
    .instr_type_i   (type_q),
    .cap_flag_i     (cap_q),
    .lsu_cap_i      (lsu_cap_i),
    .rf_wdata_ex_i  (rf_wdata_q),
    .cap_wdata_ex_i (cap_wdata_q),
    .rf_wdata_lsu_i (rf_wdata_lsu_i),
    .cap_wdata_lsu_i(cap_wdata_lsu_i),
    .wdata_o        (wb_wdata)
  );

  // A faulting load must not update the destination; stores never write.
  assign rf_we_wb_o = wb_done & we_q & waddr_nz & (type_q != WB_INSTR_STORE) &
                      ~((type_q == WB_INSTR_LOAD) & lsu_resp_err_i);

  // Gating with wb_valid_q keeps outputs at zero while empty, even with unreset data flops.
  assign rf_waddr_wb_o         = wb_valid_q ? waddr_q : 5'd0;
  assign cap_wdata_wb_o        = wb_valid_q ? wb_wdata : '0;
  assign pc_wb_o               = wb_valid_q ? pc_q : 32'd0;
  assign instr_done_wb_o       = wb_done;
  assign outstanding_load_wb_o = wb_valid_q & ~is_other;
  assign lsu_err_wb_o          = wb_done & ~is_other & lsu_resp_err_i;

`ifdef IBEX_CHERI_WB_FWD_EN
  logic [CheriCapWidth-1:0] fwd_wdata;

  ibex_cheri_wb_mux #(
    .CheriCapWidth(CheriCapWidth)
  ) u_fwd_mux (
    .instr_type_i   (WB_INSTR_OTHER),
    .cap_flag_i     (cap_q),
    .lsu_cap_i      (1'b0),
    .rf_wdata_ex_i  (rf_wdata_q),
    .cap_wdata_ex_i (cap_wdata_q),
    .rf_wdata_lsu_i (32'd0),
    .cap_wdata_lsu_i({CheriCapWidth{1'b0}}),
    .wdata_o        (fwd_wdata)
  );

  assign rf_fwd_valid_o    = wb_valid_q & we_q & is_other & waddr_nz;
  assign rf_waddr_fwd_wb_o = rf_fwd_valid_o ? waddr_q : 5'd0;
  assign rf_wdata_fwd_wb_o = rf_fwd_valid_o ? fwd_wdata : '0;
`endif

  a_accept_when_ready : assert property (@(posedge clk_i) disable iff (!rst_ni)
      en_wb_i |-> ready_wb_o)
    else $error("en_wb_i asserted while ready_wb_o is low");

  // A response orphaned by a reset is legal traffic, so it is reported, not fatal.
  a_resp_when_mem_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
      lsu_resp_valid_i |-> (wb_valid_q && !is_other))
    else $warning("LSU response with no memory op held is ignored");

endmodule

// File: tb/tb_ibex_cheri_wb_stage.sv
module tb_ibex_cheri_wb_stage;
  import ibex_pkg::*;

  localparam int CW = 91;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en_wb_i = 1'b0;
  logic [1:0]    instr_type_wb_i = 2'b00;
  logic [31:0]   pc_id_i = '0;
  logic [4:0]    rf_waddr_id_i = '0;
  logic          rf_we_id_i = 1'b0;
  logic [31:0]   rf_wdata_id_i = '0;
  logic          cap_we_id_i = 1'b0;
  logic [CW-1:0] cap_wdata_id_i = '0;
  logic          lsu_resp_valid_i = 1'b0;
  logic          lsu_resp_err_i = 1'b0;
  logic          lsu_cap_i = 1'b0;
  logic [31:0]   rf_wdata_lsu_i = '0;
  logic [CW-1:0] cap_wdata_lsu_i = '0;
  logic          ready_wb_o;
  logic [4:0]    rf_waddr_wb_o;
  logic          rf_we_wb_o;
  logic [CW-1:0] cap_wdata_wb_o;
  logic          instr_done_wb_o;
  logic          outstanding_load_wb_o;
  logic          lsu_err_wb_o;
  logic [31:0]   pc_wb_o;

  ibex_cheri_wb_stage #(.CheriCapWidth(CW), .ResetAll(1'b0)) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .en_wb_i              (en_wb_i),
    .instr_type_wb_i      (instr_type_wb_i),
    .pc_id_i              (pc_id_i),
    .rf_waddr_id_i        (rf_waddr_id_i),
    .rf_we_id_i           (rf_we_id_i),
    .rf_wdata_id_i        (rf_wdata_id_i),
    .cap_we_id_i          (cap_we_id_i),
    .cap_wdata_id_i       (cap_wdata_id_i),
    .lsu_resp_valid_i     (lsu_resp_valid_i),
    .lsu_resp_err_i       (lsu_resp_err_i),
    .lsu_cap_i            (lsu_cap_i),
    .rf_wdata_lsu_i       (rf_wdata_lsu_i),
    .cap_wdata_lsu_i      (cap_wdata_lsu_i),
    .ready_wb_o           (ready_wb_o),
    .rf_waddr_wb_o        (rf_waddr_wb_o),
    .rf_we_wb_o           (rf_we_wb_o),
    .cap_wdata_wb_o       (cap_wdata_wb_o),
    .instr_done_wb_o      (instr_done_wb_o),
    .outstanding_load_wb_o(outstanding_load_wb_o),
    .lsu_err_wb_o         (lsu_err_wb_o),
    .pc_wb_o              (pc_wb_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          we;
    logic [4:0]    waddr;
    logic [CW-1:0] wdata;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 1'b0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic we, input logic [4:0] a, input logic [CW-1:0] d, input logic err);
    exp_t e;
    e.we = we; e.waddr = a; e.wdata = d; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] t, input logic [4:0] a, input logic we,
                       input logic [31:0] d, input logic cw, input logic [CW-1:0] cd,
                       input logic [31:0] pc);
    en_wb_i = 1'b1; instr_type_wb_i = t; rf_waddr_id_i = a; rf_we_id_i = we;
    rf_wdata_id_i = d; cap_we_id_i = cw; cap_wdata_id_i = cd; pc_id_i = pc;
  endtask

  // Monitor: every retire pulse pops one expectation.
  initial begin
    exp_t e;
    while (!stim_done) begin
      @(negedge clk_i);
      if (instr_done_wb_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rf_we", rf_we_wb_o, e.we);
          check("lsu_err", lsu_err_wb_o, e.err);
          if (e.we) begin
            check("rf_waddr", rf_waddr_wb_o, e.waddr);
            check("wdata", cap_wdata_wb_o, e.wdata);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] capv;
    logic [CW-1:0] capl;
    capv = '0; capv[90] = 1'b1; capv[60:40] = 21'h1ABCD; capv[31:0] = 32'h8000_0000;
    capl = '0; capl[90] = 1'b1; capl[75:44] = 32'hCAFE_F00D; capl[31:0] = 32'h0000_1000;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", ready_wb_o, 1);
    check("rst_we", rf_we_wb_o, 0);
    check("rst_done", instr_done_wb_o, 0);
    check("rst_outstanding", outstanding_load_wb_o, 0);
    check("rst_err", lsu_err_wb_o, 0);
    check("rst_wdata", cap_wdata_wb_o, 0);
    check("rst_pc", pc_wb_o, 0);
    step();
    rst_ni = 1'b1;
    step();

    // ADD x5 = 0x10
    drive(WB_INSTR_OTHER, 5'd5, 1'b1, 32'h10, 1'b0, '0, 32'h100);
    push_exp(1'b1, 5'd5, 91'h10, 1'b0);
    @(negedge clk_i);
    check("add_ready_c0", ready_wb_o, 1);
    step();
    en_wb_i = 1'b0;
    @(negedge clk_i);
    check("add_ready_c1", ready_wb_o, 1);
    check("add_pc", pc_wb_o, 32'h100);
    step();

    // Capability result to x3, integer data must be ignored
    drive(WB_INSTR_OTHER, 5'd3, 1'b1, 32'hFFFF_FFFF, 1'b1, capv, 32'h104);
    push_exp(1'b1, 5'd3, capv, 1'b0);
    step();
    en_wb_i = 1'b0;
    step();

    // Load to x7, response 3 stall cycles later, second instr accepted in response cycle
    drive(WB_INSTR_LOAD, 5'd7, 1'b1, 32'h0, 1'b0, '0, 32'h108);
    push_exp(1'b1, 5'd7, 91'hDEAD_BEEF, 1'b0);
    step();
    en_wb_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("ld_stall_ready", ready_wb_o, 0);
      check("ld_outstanding", outstanding_load_wb_o, 1);
      step();
    end
    lsu_resp_valid_i = 1'b1; rf_wdata_lsu_i = 32'hDEAD_BEEF; lsu_cap_i = 1'b0;
    drive(WB_INSTR_OTHER, 5'd9, 1'b1, 32'h55, 1'b0, '0, 32'h10C);
    push_exp(1'b1, 5'd9, 91'h55, 1'b0);
    @(negedge clk_i);
    check("ld_resp_ready", ready_wb_o, 1);
    step();
    en_wb_i = 1'b0; lsu_resp_valid_i = 1'b0;
    step();

    // Capability load to x4 at minimum latency
    drive(WB_INSTR_LOAD, 5'd4, 1'b1, 32'h0, 1'b0, '0, 32'h110);
    push_exp(1'b1, 5'd4, capl, 1'b0);
    step();
    en_wb_i = 1'b0;
    lsu_resp_valid_i = 1'b1; lsu_cap_i = 1'b1; cap_wdata_lsu_i = capl;
    step();
    lsu_resp_valid_i = 1'b0; lsu_cap_i = 1'b0;
    step();

    // Load to x8 with error: no write, error pulse
    drive(WB_INSTR_LOAD, 5'd8, 1'b1, 32'h0, 1'b0, '0, 32'h114);
    push_exp(1'b0, 5'd8, '0, 1'b1);
    step();
    en_wb_i = 1'b0;
    lsu_resp_valid_i = 1'b1; lsu_resp_err_i = 1'b1; rf_wdata_lsu_i = 32'h1111_2222;
    step();
    lsu_resp_valid_i = 1'b0; lsu_resp_err_i = 1'b0;
    step();

    // Write to x0 is dropped but still retires
    drive(WB_INSTR_OTHER, 5'd0, 1'b1, 32'h1234, 1'b0, '0, 32'h118);
    push_exp(1'b0, 5'd0, '0, 1'b0);
    step();
    en_wb_i = 1'b0;
    step();

    // Store: held until response, never writes
    drive(WB_INSTR_STORE, 5'd10, 1'b0, 32'h0, 1'b0, '0, 32'h11C);
    push_exp(1'b0, 5'd10, '0, 1'b0);
    step();
    en_wb_i = 1'b0;
    @(negedge clk_i);
    check("st_outstanding", outstanding_load_wb_o, 1);
    step();
    lsu_resp_valid_i = 1'b1;
    step();
    lsu_resp_valid_i = 1'b0;
    step();

    // Reset while a load is held, then a stray response
    drive(WB_INSTR_LOAD, 5'd6, 1'b1, 32'h0, 1'b0, '0, 32'h120);
    step();
    en_wb_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid_outstanding", outstanding_load_wb_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    check("rst_mid_ready", ready_wb_o, 1);
    check("rst_mid_outstanding0", outstanding_load_wb_o, 0);
    check("rst_mid_pc", pc_wb_o, 0);
    step();
    rst_ni = 1'b1;
    step();
    lsu_resp_valid_i = 1'b1; rf_wdata_lsu_i = 32'h0000_AAAA;
    @(negedge clk_i);
    check("stray_we", rf_we_wb_o, 0);
    check("stray_done", instr_done_wb_o, 0);
    check("stray_ready", ready_wb_o, 1);
    check("stray_wdata", cap_wdata_wb_o, 0);
    step();
    lsu_resp_valid_i = 1'b0;
    repeat (2) step();

    check("scoreboard_empty", exp_q.size(), 0);
    stim_done = 1'b1;
    @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
